// File: rtl/bp_pkg.sv
// Types and helpers shared by the branch predictor top level and its update FIFO.
package bp_pkg;

    // Widest branch PC carried through predictor structures.
    localparam int BP_PC_WIDTH = 64;

    // One in-flight branch: its PC and the direction the predictor guessed.
    typedef struct packed {
        logic [BP_PC_WIDTH-1:0] pc;
        logic                   pred;
    } bp_entry_t;

    // Occupancy of the update FIFO.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;

    // A branch was mispredicted when the stored guess differs from the real outcome.
    function automatic logic is_mispredict(input bp_entry_t entry, input logic taken);
        return entry.pred != taken;
    endfunction

endpackage

// File: rtl/bp_fifo_mem.sv
// Entry storage for the update FIFO: one synchronous write port, one
// asynchronous read port so the head entry is visible in the pop cycle.
module bp_fifo_mem
    import bp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  bp_entry_t       wr_data,
    input  logic [AW-1:0]   rd_addr,
    output bp_entry_t       rd_data
);

    // Contents are never reset; pointers and count decide what is valid.
    bp_entry_t mem_q [DEPTH];

    // Write the pushed entry at the tail slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/bp_update_fifo.sv
// In-order queue of predicted branches awaiting resolution. Each resolve pops
// the oldest entry and emits a registered one-cycle training update for the
// predictor, flagging mispredictions and counting them (saturating).
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PC_WIDTH = BP_PC_WIDTH   // must not exceed BP_PC_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_valid,
    input  logic [PC_WIDTH-1:0]        fetch_pc,
    input  logic                       fetch_pred,
    output logic                       fetch_ready,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    input  logic                       flush,
    output logic                       upd_valid,
    output logic [PC_WIDTH-1:0]        upd_pc,
    output logic                       upd_outcome,
    output logic                       mispredict,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       resolve_err,
    output logic [31:0]                mispred_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]       head_q, head_d;
    logic [AW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    occ_state_t          occ_q, occ_d;
    logic                upd_valid_q, upd_valid_d;
    logic [PC_WIDTH-1:0] upd_pc_q, upd_pc_d;
    logic                upd_outcome_q, upd_outcome_d;
    logic                mispredict_q, mispredict_d;
    logic                resolve_err_q, resolve_err_d;
    logic [31:0]         mispred_cnt_q, mispred_cnt_d;

    logic      push;
    logic      pop;
    bp_entry_t wr_entry;
    bp_entry_t rd_entry;

    // Ready depends on registered occupancy only; a pop in the same cycle
    // does not open a slot for a push.
    assign fetch_ready = (occ_q != OCC_FULL);
    assign push        = fetch_valid && fetch_ready && !flush;
    assign pop         = resolve_valid && (occ_q != OCC_EMPTY);

    assign wr_entry.pc   = BP_PC_WIDTH'(fetch_pc);
    assign wr_entry.pred = fetch_pred;

    bp_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (tail_q),
        .wr_data (wr_entry),
        .rd_addr (head_q),
        .rd_data (rd_entry)
    );

    // Next-state: pointers, occupancy and the training update from a pop.
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        upd_valid_d   = 1'b0;
        upd_pc_d      = upd_pc_q;
        upd_outcome_d = upd_outcome_q;
        mispredict_d  = 1'b0;
        resolve_err_d = resolve_valid && (occ_q == OCC_EMPTY);
        mispred_cnt_d = mispred_cnt_q;

        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        if (pop) begin
            head_d        = head_q + AW'(1);
            upd_valid_d   = 1'b1;
            upd_pc_d      = PC_WIDTH'(rd_entry.pc);
            upd_outcome_d = resolve_taken;
            mispredict_d  = is_mispredict(rd_entry, resolve_taken);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A flush squashes everything still queued; the popped update survives.
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end

        if (mispredict_d && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end

        if (count_d == '0) begin
            occ_d = OCC_EMPTY;
        end else if (count_d == CW'(DEPTH)) begin
            occ_d = OCC_FULL;
        end else begin
            occ_d = OCC_PARTIAL;
        end
    end

    // State and registered outputs; reset acts immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            occ_q         <= OCC_EMPTY;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_outcome_q <= 1'b0;
            mispredict_q  <= 1'b0;
            resolve_err_q <= 1'b0;
            mispred_cnt_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            occ_q         <= occ_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_outcome_q <= upd_outcome_d;
            mispredict_q  <= mispredict_d;
            resolve_err_q <= resolve_err_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign upd_valid   = upd_valid_q;
    assign upd_pc      = upd_pc_q;
    assign upd_outcome = upd_outcome_q;
    assign mispredict  = mispredict_q;
    assign count       = count_q;
    assign resolve_err = resolve_err_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_bp_update_fifo.sv
// Self-checking bench for bp_update_fifo: directed scenarios plus random
// traffic, all compared against a queue-based model of the FIFO.
module tb_bp_update_fifo;

    localparam int DEPTH = 8;
    localparam int PCW   = 64;

    logic           clk;
    logic           rst;
    logic           fetch_valid;
    logic [PCW-1:0] fetch_pc;
    logic           fetch_pred;
    logic           fetch_ready;
    logic           resolve_valid;
    logic           resolve_taken;
    logic           flush;
    logic           upd_valid;
    logic [PCW-1:0] upd_pc;
    logic           upd_outcome;
    logic           mispredict;
    logic [3:0]     count;
    logic           resolve_err;
    logic [31:0]    mispred_cnt;

    bp_update_fifo #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_pred    (fetch_pred),
        .fetch_ready   (fetch_ready),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .flush         (flush),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_outcome   (upd_outcome),
        .mispredict    (mispredict),
        .count         (count),
        .resolve_err   (resolve_err),
        .mispred_cnt   (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: program-order queue of in-flight branches.
    typedef struct {
        logic [PCW-1:0] pc;
        logic           pred;
    } m_ent_t;

    m_ent_t         m_q[$];
    logic           m_uv;
    logic [PCW-1:0] m_pc;
    logic           m_out;
    logic           m_mis;
    logic           m_err;
    logic [31:0]    m_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [104:0] obs_bus;
    assign obs_bus = {fetch_ready, count, upd_valid, upd_pc, upd_outcome,
                      mispredict, resolve_err, mispred_cnt};

    function automatic logic [104:0] exp_bus();
        logic       rdy;
        logic [3:0] occ;
        rdy = (m_q.size() < DEPTH);
        occ = 4'(m_q.size());
        return {rdy, occ, m_uv, m_pc, m_out, m_mis, m_err, m_cnt};
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_uv  = 1'b0;
        m_pc  = '0;
        m_out = 1'b0;
        m_mis = 1'b0;
        m_err = 1'b0;
        m_cnt = '0;
    endtask

    // Drive one cycle of inputs, advance the model, then sample after the edge.
    task automatic cycle(input logic fv, input logic [PCW-1:0] fpc, input logic fpred,
                         input logic rv, input logic rt, input logic fl);
        logic   ready;
        logic   was_empty;
        m_ent_t e;
        fetch_valid   = fv;
        fetch_pc      = fpc;
        fetch_pred    = fpred;
        resolve_valid = rv;
        resolve_taken = rt;
        flush         = fl;
        ready     = (m_q.size() < DEPTH);
        was_empty = (m_q.size() == 0);
        m_err     = rv && was_empty;
        if (rv && !was_empty) begin
            e     = m_q.pop_front();
            m_uv  = 1'b1;
            m_pc  = e.pc;
            m_out = rt;
            m_mis = (e.pred != rt);
            if (m_mis && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end else begin
            m_uv  = 1'b0;
            m_mis = 1'b0;
        end
        if (fv && ready && !fl) begin
            e.pc   = fpc;
            e.pred = fpred;
            m_q.push_back(e);
        end
        if (fl) m_q.delete();
        @(posedge clk);
        #1;
        cyc++;
        fetch_valid   = 1'b0;
        resolve_valid = 1'b0;
        flush         = 1'b0;
    endtask

    function automatic logic [PCW-1:0] rand_pc();
        return {$urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        fetch_valid = 1'b0; fetch_pc = '0; fetch_pred = 1'b0;
        resolve_valid = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
        m_reset();
        #7;
        n_cmp++;
        if (obs_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL reset: got %h required %h", obs_bus, exp_bus());
        end
        #5 rst = 1'b0;
    endtask

    task automatic test_mispredict();
        cycle(1'b1, 64'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL mispredict_push cyc=%0d: got %h required %h", cyc, obs_bus, exp_bus());
        end
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (obs_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL mispredict_update cyc=%0d: got %h required %h", cyc, obs_bus, exp_bus());
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle(1'b1, 64'(i * 4), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (obs_bus !== exp_bus()) begin
                n_fail++;
                $display("FAIL fill i=%0d: got %h required %h", i, obs_bus, exp_bus());
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            n_cmp++;
            if (obs_bus !== exp_bus()) begin
                n_fail++;
                $display("FAIL drain i=%0d: got %h required %h", i, obs_bus, exp_bus());
            end
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, rand_pc(), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, rand_pc(), 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (obs_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL full_push_pop: got %h required %h", obs_bus, exp_bus());
        end
        for (int i = 0; i < 3; i++)
            cycle(1'b0, '0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        cycle(1'b1, rand_pc(), 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (obs_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL mid_push_pop: got %h required %h", obs_bus, exp_bus());
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            n_cmp++;
            if (obs_bus !== exp_bus()) begin
                n_fail++;
                $display("FAIL wrap_mixed i=%0d: got %h required %h", i, obs_bus, exp_bus());
            end
        end
    endtask

    task automatic test_empty_resolve();
        for (int i = 0; i < DEPTH && m_q.size() != 0; i++)
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (obs_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL empty_resolve: got %h required %h", obs_bus, exp_bus());
        end
        cycle(1'b1, 64'hABC0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (obs_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL empty_resolve_push: got %h required %h", obs_bus, exp_bus());
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL empty_resolve_after: got %h required %h", obs_bus, exp_bus());
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < DEPTH && m_q.size() != 0; i++)
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 64'h2000 + 64'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (obs_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL flush_same_cycle: got %h required %h", obs_bus, exp_bus());
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
            n_cmp++;
            if (obs_bus !== exp_bus()) begin
                n_fail++;
                $display("FAIL flush_after i=%0d: got %h required %h", i, obs_bus, exp_bus());
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++)
            cycle(1'b1, rand_pc(), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        n_cmp++;
        if (obs_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL async_reset_midcycle: got %h required %h", obs_bus, exp_bus());
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
            n_cmp++;
            if (obs_bus !== exp_bus()) begin
                n_fail++;
                $display("FAIL after_reset i=%0d: got %h required %h", i, obs_bus, exp_bus());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 6, rand_pc(), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) < 5, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 99) < 3);
            n_cmp++;
            if (obs_bus !== exp_bus()) begin
                n_fail++;
                $display("FAIL random i=%0d: got %h required %h", i, obs_bus, exp_bus());
            end
        end
    endtask

    initial begin
        test_reset();
        test_mispredict();
        test_fill_drain();
        test_full_push_pop();
        test_empty_resolve();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
